// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one RAM port between two cache controllers: port 0 (instruction
// fetch) and port 1 (data). One requester is granted at a time. Its request is
// registered onto the RAM port, and the RAM response goes back to that
// requester only.
//
// Transfer sequence: IDLE -> BUSY (RAM strobe held) -> DONE (one-cycle ready
// pulse) -> IDLE. There is always at least one IDLE cycle between grants.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   : ties go to the port not granted last.
//                       undefined : ties go to port 1 (D-side); no pointer.
//
// Ports:
//   iCLK, iRST                  clock, synchronous active-high reset
//   reqN_addr/data              requester N address and write data
//   reqN_MemRead/MemWrite       requester N strobes (both high = write)
//   reqN_rdata, reqN_ready      requester N read data and completion pulse
//   arb2mem_addr/data           registered RAM address and write data
//   arb2mem_MemRead/MemWrite    registered RAM strobes
//   mem2arb_data_in/ready       RAM read data and one-cycle completion pulse
//   grant                       one-hot current owner, 00 when idle (debug)

module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,

    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_MemRead,
    input  logic              req0_MemWrite,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ready,

    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_MemRead,
    input  logic              req1_MemWrite,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ready,

    output logic [ADDR_W-1:0] arb2mem_addr,
    output logic [DATA_W-1:0] arb2mem_data,
    output logic              arb2mem_MemRead,
    output logic              arb2mem_MemWrite,
    input  logic [DATA_W-1:0] mem2arb_data_in,
    input  logic              mem2arb_ready,

    output logic [1:0]        grant
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        grant_q, grant_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;

    logic want0, want1, pick1;

    assign want0 = req0_MemRead | req0_MemWrite;
    assign want1 = req1_MemRead | req1_MemWrite;

`ifdef ARB_ROUND_ROBIN_EN
    // High when port 1 owned the most recent grant; reset value hands the
    // first tie to port 0.
    logic last1_q, last1_d;

    assign pick1 = want1 & (~want0 | ~last1_q);
`else
    assign pick1 = want1;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        grant_d  = grant_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last1_d  = last1_q;
`endif

        case (state_q)
            StIdle: begin
                if (want0 | want1) begin
                    if (pick1) begin
                        addr_d  = req1_addr;
                        data_d  = req1_data;
                        wr_d    = req1_MemWrite;
                        // A simultaneous read+write is treated as a write.
                        rd_d    = req1_MemRead & ~req1_MemWrite;
                        grant_d = 2'b10;
                    end else begin
                        addr_d  = req0_addr;
                        data_d  = req0_data;
                        wr_d    = req0_MemWrite;
                        rd_d    = req0_MemRead & ~req0_MemWrite;
                        grant_d = 2'b01;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last1_d = pick1;
`endif
                    state_d = StBusy;
                end
            end

            StBusy: begin
                // Owner inputs are not looked at here; a withdrawn request
                // still runs to completion.
                if (mem2arb_ready) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (grant_q[1]) begin
                        ready1_d = 1'b1;
                        if (rd_q) begin
                            rdata1_d = mem2arb_data_in;
                        end
                    end else begin
                        ready0_d = 1'b1;
                        if (rd_q) begin
                            rdata0_d = mem2arb_data_in;
                        end
                    end
                    state_d = StDone;
                end
            end

            StDone: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end

            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                grant_d = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            grant_q  <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            grant_q  <= grant_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`endif

    assign arb2mem_addr     = addr_q;
    assign arb2mem_data     = data_q;
    assign arb2mem_MemRead  = rd_q;
    assign arb2mem_MemWrite = wr_q;
    assign grant            = grant_q;
    assign req0_rdata       = rdata0_q;
    assign req1_rdata       = rdata1_q;
    assign req0_ready       = ready0_q;
    assign req1_ready       = ready1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run,
// checked every cycle against a transaction-level model of the arbiter.
// Follows the ARB_ROUND_ROBIN_EN macro the same way the design does.

module tb_mem_port_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;

    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    logic        r_rd   [2];
    logic        r_wr   [2];
    bit          r_active [2];

    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_ready, req1_ready;
    logic [31:0] arb2mem_addr, arb2mem_data;
    logic        arb2mem_MemRead, arb2mem_MemWrite;
    logic [31:0] mem2arb_data_in = '0;
    logic        mem2arb_ready   = 1'b0;
    logic [1:0]  grant;

    always #5 iCLK = ~iCLK;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .req0_addr        (r_addr[0]),
        .req0_data        (r_data[0]),
        .req0_MemRead     (r_rd[0]),
        .req0_MemWrite    (r_wr[0]),
        .req0_rdata       (req0_rdata),
        .req0_ready       (req0_ready),
        .req1_addr        (r_addr[1]),
        .req1_data        (r_data[1]),
        .req1_MemRead     (r_rd[1]),
        .req1_MemWrite    (r_wr[1]),
        .req1_rdata       (req1_rdata),
        .req1_ready       (req1_ready),
        .arb2mem_addr     (arb2mem_addr),
        .arb2mem_data     (arb2mem_data),
        .arb2mem_MemRead  (arb2mem_MemRead),
        .arb2mem_MemWrite (arb2mem_MemWrite),
        .mem2arb_data_in  (mem2arb_data_in),
        .mem2arb_ready    (mem2arb_ready),
        .grant            (grant)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_owner = -1;   // -1: nobody owns the RAM port
    bit          m_done  = 0;    // owner is in its ready-pulse cycle
    int          m_last  = 1;
    logic [31:0] m_addr  = '0, m_data = '0;
    logic        m_rd = 0, m_wr = 0;
    logic [1:0]  m_grant = '0;
    logic [1:0]  m_ready = '0;
    logic [31:0] m_rdata [2] = '{0, 0};

    always @(posedge iCLK) begin
        bit want [2];
        int w;
        if (iRST) begin
            m_owner = -1; m_done = 0; m_last = 1;
            m_addr = '0; m_data = '0; m_rd = 0; m_wr = 0;
            m_grant = '0; m_ready = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_done) begin
            m_done = 0; m_owner = -1; m_grant = '0; m_ready = '0;
        end else if (m_owner >= 0) begin
            if (mem2arb_ready) begin
                if (m_rd) m_rdata[m_owner] = mem2arb_data_in;
                m_rd = 0; m_wr = 0;
                m_ready[m_owner] = 1'b1;
                m_done = 1;
            end
        end else begin
            want[0] = r_rd[0] || r_wr[0];
            want[1] = r_rd[1] || r_wr[1];
            if (want[0] || want[1]) begin
                if (want[0] && want[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = 1 - m_last;
`else
                    w = 1;
`endif
                end else begin
                    w = want[1] ? 1 : 0;
                end
                m_owner = w; m_last = w;
                m_addr = r_addr[w]; m_data = r_data[w];
                m_wr = r_wr[w]; m_rd = r_rd[w] && !r_wr[w];
                m_grant = (w == 1) ? 2'b10 : 2'b01;
            end
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge iCLK) begin
        check("grant",     grant,            m_grant);
        check("mem_addr",  arb2mem_addr,     m_addr);
        check("mem_data",  arb2mem_data,     m_data);
        check("mem_rd",    arb2mem_MemRead,  m_rd);
        check("mem_wr",    arb2mem_MemWrite, m_wr);
        check("ready0",    req0_ready,       m_ready[0]);
        check("ready1",    req1_ready,       m_ready[1]);
        check("rdata0",    req0_rdata,       m_rdata[0]);
        check("rdata1",    req1_rdata,       m_rdata[1]);
    end

    // ---------------- RAM responder and requesters ----------------
    logic [31:0] ram [256];
    int          ram_cnt = 0, ram_lat = 2;
    bit          ram_rand = 0, ram_w = 0;
    logic [7:0]  ram_a;
    logic [31:0] ram_d;
    bit          rand_mode = 0, auto_reissue = 0;

    int          rdy_cnt [2];
    int          rd_cycles;
    logic [1:0]  prev_grant = '0;
    logic [1:0]  g_q [$];
    int          g_cyc [$];
    int          rdy_cyc [$];

    task automatic ram_step();
        if (mem2arb_ready) begin
            mem2arb_ready   = 1'b0;
            mem2arb_data_in = $urandom;
        end else begin
            if (ram_cnt == 0 && (arb2mem_MemRead || arb2mem_MemWrite)) begin
                ram_cnt = ram_rand ? int'($urandom_range(1, 5)) : ram_lat;
                ram_a = arb2mem_addr[7:0]; ram_w = arb2mem_MemWrite; ram_d = arb2mem_data;
            end
            if (ram_cnt > 0) begin
                ram_cnt--;
                if (ram_cnt == 0) begin
                    mem2arb_ready = 1'b1;
                    if (ram_w) ram[ram_a] = ram_d;
                    else mem2arb_data_in = ram[ram_a];
                end
            end
        end
    endtask

    task automatic issue(input int p, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        r_active[p] = 1; r_rd[p] = rd; r_wr[p] = wr; r_addr[p] = a; r_data[p] = d;
    endtask

    task automatic issue_rand(input int p);
        int k;
        k = int'($urandom_range(0, 3));
        issue(p, k != 2, k >= 2, $urandom_range(0, 255), $urandom);
    endtask

    task automatic req_step();
        for (int p = 0; p < 2; p++) begin
            logic rdy;
            rdy = (p == 1) ? req1_ready : req0_ready;
            if (r_active[p] && rdy) begin
                if (auto_reissue) issue_rand(p);
                else begin r_active[p] = 0; r_rd[p] = 0; r_wr[p] = 0; end
            end else if (!r_active[p] && rand_mode && $urandom_range(0, 3) == 0) begin
                issue_rand(p);
            end
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        cyc++;
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            g_q.push_back(grant); g_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (arb2mem_MemRead) rd_cycles++;
        if (req0_ready) begin rdy_cnt[0]++; rdy_cyc.push_back(cyc); end
        if (req1_ready) begin rdy_cnt[1]++; rdy_cyc.push_back(cyc); end
        ram_step();
        req_step();
    endtask

    task automatic clear_stats();
        rdy_cnt[0] = 0; rdy_cnt[1] = 0; rd_cycles = 0;
        g_q.delete(); g_cyc.delete(); rdy_cyc.delete();
    endtask

    task automatic drop_requests();
        for (int p = 0; p < 2; p++) begin
            r_active[p] = 0; r_rd[p] = 0; r_wr[p] = 0;
        end
    endtask

    task automatic do_reset();
        drop_requests();
        ram_cnt = 0; mem2arb_ready = 1'b0;
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((r_active[0] || r_active[1] || grant != 2'b00) && n < budget) begin
            tick();
            n++;
        end
        check(name, n < budget, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        drop_requests();
        for (int p = 0; p < 2; p++) begin r_addr[p] = '0; r_data[p] = '0; end

        // Reset with idle stimulus.
        do_reset();
        check("rst_grant", grant, 2'b00);
        check("rst_strobes", {arb2mem_MemRead, arb2mem_MemWrite}, 2'b00);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        check("rst_addr", arb2mem_addr, 32'd0);

        // Reset while BUSY; the later RAM pulse must not produce a ready.
        clear_stats();
        ram_lat = 3;
        issue(0, 1, 0, 32'd16, 32'd0);
        tick(); tick();
        iRST = 1'b1;
        drop_requests();
        tick();
        iRST = 1'b0;
        check("midrst_grant", grant, 2'b00);
        check("midrst_rd", arb2mem_MemRead, 1'b0);
        repeat (6) tick();
        check("midrst_no_ready", rdy_cnt[0] + rdy_cnt[1], 0);

        // Port 0 read, addr 4, RAM answers 3 cycles after strobe.
        do_reset(); clear_stats();
        ram_lat = 3; ram[4] = 32'd234;
        issue(0, 1, 0, 32'd4, 32'd0);
        tick();
        check("p0rd_addr", arb2mem_addr, 32'd4);
        check("p0rd_strobe", {arb2mem_MemRead, arb2mem_MemWrite}, 2'b10);
        check("p0rd_grant", grant, 2'b01);
        wait_idle("p0rd_timeout", 30);
        check("p0rd_rdata", req0_rdata, 32'd234);
        check("p0rd_ready_cycles", rdy_cnt[0], 1);
        check("p0rd_no_ready1", rdy_cnt[1], 0);
        check("p0rd_strobe_cycles", rd_cycles, 3);

        // Port 1 read (sets rdata), then write addr 132 data 20.
        ram[8] = 32'h55;
        issue(1, 1, 0, 32'd8, 32'd0);
        wait_idle("p1rd_timeout", 30);
        check("p1rd_rdata", req1_rdata, 32'h55);
        clear_stats(); ram_lat = 2;
        issue(1, 0, 1, 32'd132, 32'd20);
        tick();
        check("p1wr_strobe", {arb2mem_MemRead, arb2mem_MemWrite}, 2'b01);
        check("p1wr_addr", arb2mem_addr, 32'd132);
        check("p1wr_data", arb2mem_data, 32'd20);
        check("p1wr_grant", grant, 2'b10);
        wait_idle("p1wr_timeout", 30);
        check("p1wr_ready_cycles", rdy_cnt[1], 1);
        check("p1wr_no_ready0", rdy_cnt[0], 0);
        check("p1wr_rdata_kept", req1_rdata, 32'h55);
        check("p1wr_ram", ram[132], 32'd20);

        // Simultaneous reads, addr 8 (port 0) and 0x80 (port 1).
        do_reset(); clear_stats();
        ram_lat = 2; ram[8] = 32'd11; ram[128] = 32'd22;
        issue(0, 1, 0, 32'd8, 32'd0);
        issue(1, 1, 0, 32'h80, 32'd0);
        wait_idle("tie_timeout", 40);
        check("tie_grants", g_q.size(), 2);
        if (g_q.size() >= 2 && rdy_cyc.size() >= 1) begin
`ifdef ARB_ROUND_ROBIN_EN
            check("tie_first", g_q[0], 2'b01);
            check("tie_second", g_q[1], 2'b10);
`else
            check("tie_first", g_q[0], 2'b10);
            check("tie_second", g_q[1], 2'b01);
`endif
            check("tie_idle_gap", g_cyc[1] - rdy_cyc[0], 2);
        end
        check("tie_rdata0", req0_rdata, 32'd11);
        check("tie_rdata1", req1_rdata, 32'd22);

        // Both ports request continuously for 6 transfers.
        do_reset(); clear_stats();
        ram_lat = 1; auto_reissue = 1;
        issue_rand(0); issue_rand(1);
        begin
            int n = 0;
            while (rdy_cnt[0] + rdy_cnt[1] < 6 && n < 200) begin tick(); n++; end
            check("cont_timeout", n < 200, 1'b1);
        end
        auto_reissue = 0;
        drop_requests();
        check("cont_grants", g_q.size(), 6);
        for (int i = 0; i < 6 && i < g_q.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            check($sformatf("cont_grant%0d", i), g_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            check($sformatf("cont_grant%0d", i), g_q[i], 2'b10);
`endif
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_ready0", rdy_cnt[0], 3);
        check("cont_ready1", rdy_cnt[1], 3);
`else
        check("cont_ready0", rdy_cnt[0], 0);
        check("cont_ready1", rdy_cnt[1], 6);
`endif
        wait_idle("cont_drain", 30);

        // RAM ready pulsed while idle, then a request withdrawn mid-BUSY.
        do_reset(); clear_stats();
        tick();
        mem2arb_ready = 1'b1; mem2arb_data_in = 32'd99;
        tick(); tick();
        check("idlepulse_grant", grant, 2'b00);
        check("idlepulse_ready", rdy_cnt[0] + rdy_cnt[1], 0);
        check("idlepulse_rdata0", req0_rdata, 32'd0);
        ram_lat = 4;
        issue(0, 1, 0, 32'd12, 32'd0);
        tick(); tick();
        r_rd[0] = 1'b0;             // withdrawn, still waiting for ready
        wait_idle("withdraw_timeout", 30);
        check("withdraw_ready", rdy_cnt[0], 1);
        check("withdraw_rdata", req0_rdata, ram[12]);

        // Randomized traffic against the model.
        do_reset(); clear_stats();
        rand_mode = 1; ram_rand = 1;
        repeat (3000) tick();
        rand_mode = 0;
        wait_idle("rand_drain", 100);
        check("rand_activity", (rdy_cnt[0] > 20) && (rdy_cnt[1] > 20), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single RAM port between the instruction-fetch cache controller (port 0) and the data cache controller (port 1). Each requester uses the same MemRead/MemWrite/addr/data/ready handshake that a cache controller drives toward RAM. The arbiter grants one requester at a time, registers its request onto the RAM port, and routes the RAM response back to that requester only. It sits between both cache controllers and the RAM model or on-chip memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
iCLK  in  1  clock, all state changes on rising edge
iRST  in  1  synchronous reset, active-high
req0_addr  in  ADDR_W  port 0 (I-side) address
req0_data  in  DATA_W  port 0 write data
req0_MemRead  in  1  port 0 read request
req0_MemWrite  in  1  port 0 write request
req0_rdata  out  DATA_W  port 0 read data
req0_ready  out  1  port 0 completion pulse
req1_addr, req1_data, req1_MemRead, req1_MemWrite, req1_rdata, req1_ready  same as port 0, for port 1 (D-side)
arb2mem_addr  out  ADDR_W  RAM address
arb2mem_data  out  DATA_W  RAM write data
arb2mem_MemRead  out  1  RAM read strobe
arb2mem_MemWrite  out  1  RAM write strobe
mem2arb_data_in  in  DATA_W  RAM read data
mem2arb_ready  in  1  RAM completion, one-cycle pulse
grant  out  2  one-hot current owner (debug). 00 when idle.

Behaviour:
- Reset is synchronous and active-high on iRST. On iRST=1 at an edge, state goes to IDLE and every output is cleared to 0: all arb2mem_*, reqN_ready, reqN_rdata, grant. The last-granted pointer clears to port 1, so port 0 wins the first round-robin tie. Reset mid-transaction abandons the transfer. A later mem2arb_ready is ignored.
- Requester protocol: hold MemRead or MemWrite plus addr/data stable until reqN_ready=1. Deassert by the next edge. If both MemRead and MemWrite are high, it is a write.
- FSM has three states:
  - IDLE: sample request lines.
    - If any request is present, select the winner. Latch its addr, data and rd/wr into the arb2mem_* registers. Set grant. Go to BUSY.
    - If there is no request, stay in IDLE.
    - mem2arb_ready is ignored in IDLE.
  - BUSY: arb2mem_* are held constant from the latched values. The owner's inputs are not re-sampled.
    - On mem2arb_ready=1: clear arb2mem_MemRead/MemWrite. Register mem2arb_data_in into the owner's reqN_rdata. Set the owner's reqN_ready=1. Go to DONE.
    - The other requester's ready stays 0.
  - DONE: the owner's reqN_ready is high for exactly this one cycle. Next edge: ready clears, grant goes to 00, state goes to IDLE.
- reqN_rdata holds its value until that port's next completed read. For writes, rdata is unchanged.
- Latency: request asserted before edge t gives the RAM strobe visible after t. mem2arb_ready sampled at edge u gives reqN_ready visible after u. Minimum request-to-ready is 2 cycles plus RAM latency.
- Back-to-back: after DONE there is always one IDLE cycle before the next grant. Maximum throughput is one transfer per (RAM latency + 3) cycles.
- Request withdrawn while BUSY: the transfer still completes and the ready pulse is still issued.
- Simultaneous requests in IDLE are resolved by the policy below. The loser keeps waiting with no ready pulse.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests, grant the port that was not granted last. The last-granted pointer updates on every grant.
- Undefined: fixed priority, port 1 (D-side) always wins ties. The pointer is absent.
- Single-request behaviour is identical in both builds.

Test Plan:
- Reset with stimulus idle -> after one edge all outputs are 0, grant=00. Then assert iRST while BUSY -> outputs return to 0. A mem2arb_ready one cycle later produces no reqN_ready.
- Port 0 read, addr=4. RAM returns 234 with ready 3 cycles after its strobe -> arb2mem_addr=4, MemRead=1 only while BUSY. req0_rdata=234 and req0_ready high for exactly 1 cycle. req1_ready stays 0.
- Port 1 write, addr=132, data=20 -> arb2mem_MemWrite=1, addr=132, data=20 until mem2arb_ready. Then req1_ready pulses and req1_rdata is unchanged.
- Both ports read in the same cycle (addr 8 and 0x80), RAM latency 2 -> without the macro, port 1 is served, then port 0, with one IDLE gap between them. With ARB_ROUND_ROBIN_EN, port 0 is served first.
- With ARB_ROUND_ROBIN_EN, both ports request continuously for 6 transfers -> grant alternates 01,10,01,10,01,10. Each port receives exactly 3 ready pulses.
- mem2arb_ready pulsed while IDLE, and req0 dropped mid-BUSY -> the idle pulse is ignored with no state change. The withdrawn transfer still completes and issues req0_ready.
